// File: rtl/seq_mult.sv
// seq_mult: sequential shift-add multiplier, W x W -> 2W bits.
//   Signed (two's complement) or unsigned, selected per operation.
//   The multiply runs on operand magnitudes; the sign is applied
//   once in the FIX state.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   start       request; idles high, a 1->0 transition launches
//   signed_mode 1 = two's complement operands/product, sampled at launch
//   op_a, op_b  multiplicand / multiplier, sampled at launch
//   prod        2W-bit result, valid while done=1
//   done        operation complete (held until next launch/reset)
//   busy        operation in progress
//
// Optional build macro SEQ_MULT_EARLY_TERM_EN: leave RUN as soon as the
// remaining multiplier bits are all zero. Results are unchanged; only
// the latency shrinks.
module seq_mult #(
  parameter int W     = 8,
  parameter int CNT_W = $clog2(W+1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [W-1:0]   op_a,
  input  logic [W-1:0]   op_b,
  output logic [2*W-1:0] prod,
  output logic           done,
  output logic           busy
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t         state, state_nxt;
  logic           start_q;
  logic [2*W-1:0] acc, mcand;
  logic [W-1:0]   mplier;
  logic [CNT_W-1:0] cnt;
  logic           neg;

  logic           launch;
  logic [W-1:0]   mag_a, mag_b;
  logic [W-1:0]   mplier_sh;
  logic [CNT_W-1:0] cnt_dec;
  logic           run_end;

  // Falling edge of start, honoured only when no operation is in flight.
  assign launch = start_q & ~start & ((state == IDLE) | (state == DONE));

  // Magnitudes as W-bit unsigned; -2^(W-1) negates to itself, which is
  // the correct unsigned magnitude 2^(W-1).
  assign mag_a = (signed_mode & op_a[W-1]) ? (~op_a + 1'b1) : op_a;
  assign mag_b = (signed_mode & op_b[W-1]) ? (~op_b + 1'b1) : op_b;

  assign mplier_sh = mplier >> 1;
  assign cnt_dec   = cnt - CNT_W'(1);

`ifdef SEQ_MULT_EARLY_TERM_EN
  assign run_end = (cnt_dec == '0) | (mplier_sh == '0);
`else
  assign run_end = (cnt_dec == '0);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch) state_nxt = RUN;
      RUN:     if (run_end) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    if (launch) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_q <= 1'b1;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      prod    <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      start_q <= start;
      if (launch) begin
        acc    <= '0;
        mcand  <= {{W{1'b0}}, mag_a};
        mplier <= mag_b;
        cnt    <= CNT_W'(W);
        neg    <= signed_mode & (op_a[W-1] ^ op_b[W-1]);
        prod   <= '0;
        done   <= 1'b0;
        busy   <= 1'b1;
      end else begin
        case (state)
          RUN: begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier_sh;
            cnt    <= cnt_dec;
          end
          FIX: begin
            // Negating zero yields zero, so no -0 artefact.
            prod <= neg ? (~acc + 1'b1) : acc;
            done <= 1'b1;
            busy <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_mult.sv
// tb_seq_mult: directed bench for seq_mult (W=8). Expected products and
// latencies are hand-computed; early-terminate latencies are selected
// when SEQ_MULT_EARLY_TERM_EN is defined.
module tb_seq_mult;

  localparam int W = 8;
`ifdef SEQ_MULT_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic           signed_mode;
  logic [W-1:0]   op_a, op_b;
  logic [2*W-1:0] prod;
  logic           done, busy;

  int total = 0;
  int bad   = 0;

  seq_mult #(.W(W)) dut (
    .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode),
    .op_a(op_a), .op_b(op_b), .prod(prod), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Drive a start falling edge; returns just after the launch edge.
  task automatic launch(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b,
                        input string tag);
    signed_mode = sm; op_a = a; op_b = b; start = 1'b0;
    tick();
    start = 1'b1;
    chk({tag, "_launch_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_launch_busy"}, {31'd0, busy}, 32'd1);
  endtask

  // Count edges after launch until done; check latency, busy and product.
  task automatic wait_done(input int lat_full, input int lat_et,
                           input logic [2*W-1:0] p_exp, input string tag);
    int n = 0;
    bit seen = 1'b0;
    int lat = ET ? lat_et : lat_full;
    for (int i = 1; i <= 20 && !seen; i++) begin
      tick();
      n = i;
      if (done === 1'b1) seen = 1'b1;
      else chk({tag, "_busy_run"}, {31'd0, busy}, 32'd1);
    end
    chk({tag, "_latency"}, seen ? n : 99, lat);
    chk({tag, "_prod"}, {16'd0, prod}, {16'd0, p_exp});
    chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b1; signed_mode = 1'b0; op_a = '0; op_b = '0;
    #1;
    chk("rst_prod", {16'd0, prod}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    #20 reset = 1'b1;
    tick();

    // Signed basics.
    launch(1'b1, 8'd2, 8'hFC, "s_2x-4");
    wait_done(9, 4, 16'hFFF8, "s_2x-4");
    launch(1'b1, 8'd13, 8'd7, "s_13x7");
    wait_done(9, 4, 16'h005B, "s_13x7");
    launch(1'b1, 8'd0, 8'hFF, "s_0x-1");
    wait_done(9, 2, 16'h0000, "s_0x-1");
    launch(1'b1, 8'h80, 8'h80, "s_min2");
    wait_done(9, 9, 16'h4000, "s_min2");
    launch(1'b1, 8'h7F, 8'h80, "s_maxmin");
    wait_done(9, 9, 16'hC080, "s_maxmin");

    // Unsigned, second op launched straight from DONE.
    launch(1'b0, 8'd200, 8'd200, "u_200sq");
    wait_done(9, 9, 16'h9C40, "u_200sq");
    tick();
    chk("u_hold_prod", {16'd0, prod}, 32'h9C40);
    chk("u_hold_done", {31'd0, done}, 32'd1);
    launch(1'b0, 8'd255, 8'd3, "u_255x3");
    chk("u_255x3_prod_clr", {16'd0, prod}, 32'd0);
    wait_done(9, 3, 16'h02FD, "u_255x3");

    // Second falling edge mid-operation is ignored.
    launch(1'b0, 8'd3, 8'd200, "ign");
    tick(); tick(); tick();
    start = 1'b0; op_a = 8'd1; op_b = 8'd1;
    tick();
    start = 1'b1;
    chk("ign_busy_e4", {31'd0, busy}, 32'd1);
    for (int i = 5; i <= 8; i++) tick();
    tick();
    chk("ign_done_e9", {31'd0, done}, 32'd1);
    chk("ign_prod", {16'd0, prod}, 32'h0258);
    tick(); tick(); tick();
    chk("ign_no_relaunch_done", {31'd0, done}, 32'd1);
    chk("ign_no_relaunch_prod", {16'd0, prod}, 32'h0258);

    // Reset mid-operation.
    launch(1'b1, 8'd5, 8'd5, "rmid");
    for (int i = 1; i <= 4; i++) tick();
    reset = 1'b0;
    #1;
    chk("rmid_done", {31'd0, done}, 32'd0);
    chk("rmid_busy", {31'd0, busy}, 32'd0);
    chk("rmid_prod", {16'd0, prod}, 32'd0);
    #12 reset = 1'b1;
    tick();
    chk("rmid_idle_busy", {31'd0, busy}, 32'd0);
    launch(1'b1, 8'd2, 8'hFC, "post_rst");
    wait_done(9, 4, 16'hFFF8, "post_rst");

    // Early-terminate corner operands (fixed latency without the macro).
    launch(1'b0, 8'h55, 8'd1, "et_b1");
    wait_done(9, 2, 16'h0055, "et_b1");
    launch(1'b0, 8'h55, 8'd0, "et_b0");
    wait_done(9, 2, 16'h0000, "et_b0");
    launch(1'b0, 8'd3, 8'h40, "et_b40");
    wait_done(9, 8, 16'h00C0, "et_b40");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_mult.md
Name: seq_mult

Overview:
- Parametrised sequential shift-add multiplier with the start/done handshake already used by the program-level benches.
- Multiplies two W-bit operands, signed two's-complement or unsigned selectable per operation, into a 2W-bit product.
- Sits beside the ALU as a multi-cycle functional unit, so programs such as the 8x8 product can be checked against a hardware result.

Parameters:
- W, 8, operand width in bits (min 2); product is 2W bits.
- CNT_W, $clog2(W+1), width of the internal bit counter.

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request; idles high; a 1->0 transition launches an operation.
- signed_mode  input  1  1 = operands and product are two's complement; 0 = unsigned. Sampled at launch.
- op_a  input  W  multiplicand, sampled at launch.
- op_b  input  W  multiplier, sampled at launch.
- prod  output  2W  result; valid while done=1.
- done  output  1  operation complete.
- busy  output  1  operation in progress.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; prod=0; done=0; busy=0.
  - start_q=1; all internal registers cleared.
  - Reset mid-operation aborts the operation with no residual effect.
- Edge detection:
  - start_q <= start on every edge.
  - launch = start_q & ~start & (state==IDLE or DONE).
  - A start falling edge while in RUN or FIX is ignored.
  - Holding start low does not relaunch.
- States: IDLE, RUN, FIX, DONE.
- Launch edge (from IDLE or DONE):
  - mag_a = |op_a| if signed_mode else op_a; mag_b likewise, as W-bit unsigned. Note |-2^(W-1)| = 2^(W-1) fits.
  - neg = signed_mode & (op_a[W-1] ^ op_b[W-1]).
  - acc=0; mcand = zero-extended mag_a (2W bits); mplier = mag_b; cnt = W.
  - done=0, busy=1, state=RUN. prod is cleared to 0.
- RUN, each edge:
  - if mplier[0], acc += mcand (2W-bit, no overflow possible).
  - mcand <<= 1; mplier >>= 1; cnt -= 1.
  - When the decremented cnt is 0, go to FIX.
- FIX edge:
  - prod = neg ? (~acc + 1) : acc, truncated to 2W bits.
  - done=1, busy=0, state=DONE.
- Latency: done rises on edge W+1 after the launch edge (edge 9 for W=8).
- DONE:
  - prod and done held stable until the next launch or reset.
  - Launch from DONE clears done on the launch edge.
- Boundary results:
  - Zero operand: prod=0 with the sign fix applied, so never -0 artefacts.
  - Signed -2^(W-1) * -2^(W-1) = +2^(2W-2), representable.
- busy and done are never both 1. Outputs are registered with no combinational input-to-output path.

Optional Feature:
- Macro SEQ_MULT_EARLY_TERM_EN.
- Defined:
  - In RUN, also go to FIX when the shifted mplier is 0.
  - Latency becomes (index of highest set bit of mag_b) + 2 edges, minimum 2 (mag_b = 0 or 1).
  - Results are identical to the disabled build.
- Undefined:
  - Fixed latency of W+1 edges regardless of operands.

Test Plan (W=8):
- signed_mode=1, op_a=2, op_b=-4, pulse start 1->0 -> done on edge 9 after launch; prod=16'hFFF8 (-8); busy high edges 1-8.
- signed_mode=1, pairs 13*7, 0*-1, -128*-128, 127*-128 -> prod = 16'h005B, 16'h0000, 16'h4000, 16'hC080, each with fixed 9-edge latency.
- signed_mode=0, op_a=8'd200, op_b=8'd200 -> prod=16'h9C40; then op_a=255, op_b=3 -> 16'h02FD, launched directly from DONE; done drops on the launch edge.
- Launch, then a second start falling edge at edge 4 -> ignored; first result correct at edge 9; no second operation.
- Launch, then reset=0 at edge 5 -> immediately done=0, busy=0, prod=0; after release, a new launch of 2*-4 -> 16'hFFF8 on edge 9.
- SEQ_MULT_EARLY_TERM_EN: op_b=1 -> done at edge 2; op_b=0 -> edge 2, prod=0; op_b=8'h40 -> edge 8. Without the macro, all three complete at edge 9.
